// File: rtl/id_token_gen_pkg.sv
// Shared constants, FSM state type and character-class helpers for the identifier
// token generator and recognizer benches.
package id_pkg;

  localparam logic [7:0] CH_A_LO = 8'h61;
  localparam logic [7:0] CH_A_UP = 8'h41;
  localparam logic [7:0] CH_0    = 8'h30;
  localparam logic [7:0] CH_SP   = 8'h20;

  typedef enum logic [1:0] {IDLE, LET, DIG, SEP} state_t;

  function automatic logic is_letter(input logic [7:0] c);
    return ((c >= CH_A_UP) && (c <= 8'h5a)) || ((c >= CH_A_LO) && (c <= 8'h7a));
  endfunction

  function automatic logic is_digit(input logic [7:0] c);
    return (c >= CH_0) && (c <= 8'h39);
  endfunction

endpackage

// File: rtl/id_token_gen_if.sv
// Character bus between the token generator (master) and an identifier recognizer (slave).
interface id_token_gen_if;
  logic [7:0] char;
  logic       char_valid;
  logic       char_ready;
  logic       expect_id;

  modport master (output char, output char_valid, output expect_id, input char_ready);
  modport slave  (input char, input char_valid, input expect_id, output char_ready);
endinterface

// File: rtl/id_token_gen_mod_counter.sv
// Loadable wrap-around counter modulo MOD; load values up to 2*MOD-1 are reduced on load.
module id_mod_counter #(
  parameter int unsigned MOD = 10,
  parameter int unsigned W   = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         inc,
  output logic [W-1:0] value,
  output logic [W-1:0] next_value,
  output logic [W-1:0] load_red
);

  localparam logic [W-1:0] MOD_W = W'(MOD);
  localparam logic [W-1:0] MAX_W = W'(MOD - 1);

  assign load_red   = (load_val >= MOD_W) ? load_val - MOD_W : load_val;
  assign next_value = (value == MAX_W) ? '0 : value + W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      value <= '0;
    end else if (load) begin
      value <= load_red;
    end else if (inc) begin
      value <= next_value;
    end
  end

endmodule

// File: rtl/id_token_gen.sv
// Emits one identifier token (letters then digits) on the char bus with the expected
// recognizer output; define ID_GEN_SEP_EN to append a separator char after each token.
module id_token_gen
  import id_pkg::*;
#(
  parameter int unsigned CNT_W = 4
`ifdef ID_GEN_SEP_EN
  , parameter logic [7:0] SEP_CHAR = CH_SP
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] letter_cnt,
  input  logic [CNT_W-1:0] digit_cnt,
  input  logic [4:0]       first_letter,
  input  logic [3:0]       first_digit,
  input  logic             upper,
  id_token_gen_if.master   bus,
  output logic             busy,
  output logic             done
);

  state_t           state;
  logic [CNT_W-1:0] lrem;
  logic [CNT_W-1:0] drem;
  logic             upper_r;
  logic             hs;
  logic             cap;
  logic [4:0]       lidx, lnxt, lred;
  logic [3:0]       didx, dnxt, dred;

  assign hs  = bus.char_valid && bus.char_ready;
  assign cap = (state == IDLE) && start;

  id_mod_counter #(.MOD(26), .W(5)) u_letter (
    .clk(clk), .reset(reset), .load(cap), .load_val(first_letter),
    .inc((state == LET) && hs), .value(lidx), .next_value(lnxt), .load_red(lred)
  );

  id_mod_counter #(.MOD(10), .W(4)) u_digit (
    .clk(clk), .reset(reset), .load(cap), .load_val(first_digit),
    .inc((state == DIG) && hs), .value(didx), .next_value(dnxt), .load_red(dred)
  );

  function automatic logic [7:0] letter_ch(input logic up, input logic [4:0] i);
    return (up ? CH_A_UP : CH_A_LO) + {3'b000, i};
  endfunction

  function automatic logic [7:0] digit_ch(input logic [3:0] d);
    return CH_0 + {4'b0000, d};
  endfunction

  // The next char is registered at the same edge that consumes the current one, so the
  // counters' look-ahead values feed the char register to avoid bubbles.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      lrem           <= '0;
      drem           <= '0;
      upper_r        <= 1'b0;
      bus.char       <= '0;
      bus.char_valid <= 1'b0;
      bus.expect_id  <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          lrem          <= letter_cnt;
          drem          <= digit_cnt;
          upper_r       <= upper;
          bus.expect_id <= 1'b0;
          if (letter_cnt != '0) begin
            state          <= LET;
            bus.char       <= letter_ch(upper, lred);
            bus.char_valid <= 1'b1;
            busy           <= 1'b1;
          end else if (digit_cnt != '0) begin
            state          <= DIG;
            bus.char       <= digit_ch(dred);
            bus.char_valid <= 1'b1;
            busy           <= 1'b1;
          end else begin
`ifdef ID_GEN_SEP_EN
            state          <= SEP;
            bus.char       <= SEP_CHAR;
            bus.char_valid <= 1'b1;
            busy           <= 1'b1;
`else
            done           <= 1'b1;
`endif
          end
        end
        LET: if (hs) begin
          if (lrem != CNT_W'(1)) begin
            lrem     <= lrem - CNT_W'(1);
            bus.char <= letter_ch(upper_r, lnxt);
          end else begin
            lrem <= '0;
            if (drem != '0) begin
              // Digits after at least one letter complete a valid identifier.
              state         <= DIG;
              bus.char      <= digit_ch(didx);
              bus.expect_id <= 1'b1;
            end else begin
`ifdef ID_GEN_SEP_EN
              state          <= SEP;
              bus.char       <= SEP_CHAR;
              bus.expect_id  <= 1'b0;
`else
              state          <= IDLE;
              bus.char       <= '0;
              bus.char_valid <= 1'b0;
              bus.expect_id  <= 1'b0;
              busy           <= 1'b0;
              done           <= 1'b1;
`endif
            end
          end
        end
        DIG: if (hs) begin
          if (drem != CNT_W'(1)) begin
            drem     <= drem - CNT_W'(1);
            bus.char <= digit_ch(dnxt);
          end else begin
            drem <= '0;
`ifdef ID_GEN_SEP_EN
            state          <= SEP;
            bus.char       <= SEP_CHAR;
            bus.expect_id  <= 1'b0;
`else
            state          <= IDLE;
            bus.char       <= '0;
            bus.char_valid <= 1'b0;
            bus.expect_id  <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b1;
`endif
          end
        end
`ifdef ID_GEN_SEP_EN
        SEP: if (hs) begin
          state          <= IDLE;
          bus.char       <= '0;
          bus.char_valid <= 1'b0;
          bus.expect_id  <= 1'b0;
          busy           <= 1'b0;
          done           <= 1'b1;
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule
